// File: rtl/my_pkg.sv
// my_pkg: shared ALU select codes, controller states, opcode/funct values and datapath mux selects
package my_pkg;
  localparam int SEL_WIDTH = 3;
  typedef enum logic [SEL_WIDTH-1:0] {
    ALU_ADD, ALU_SUB, ALU_ANND, ALU_OOR, ALU_NOOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alusel_t;
  typedef enum logic [3:0] {
    RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXE,
    RWB, IEXE, IWB, BRANCH, JUMP, JAL, JR, ILL
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [1:0] SRCA_PC = 2'd0;
  localparam logic [1:0] SRCA_A  = 2'd1;
  localparam logic [1:0] SRCA_B  = 2'd2;
  localparam logic [2:0] SRCB_B     = 3'd0;
  localparam logic [2:0] SRCB_FOUR  = 3'd1;
  localparam logic [2:0] SRCB_IMM   = 3'd2;
  localparam logic [2:0] SRCB_IMMSH = 3'd3;
  localparam logic [2:0] SRCB_ZIMM  = 3'd4;
  localparam logic [2:0] SRCB_SHAMT = 3'd5;
  localparam logic [1:0] PCSRC_ALU = 2'd0;
  localparam logic [1:0] PCSRC_OUT = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;
  localparam logic [1:0] PCSRC_A   = 2'd3;
  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;
  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC  = 2'd2;
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] srca;
    logic [2:0] srcb;
    alusel_t    alusel;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       bne;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps R-type funct, or the I-type opcode used as a hint, to the ALU select code
module alu_decoder
  import my_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alusel_t    alusel
);
  always_comb
    alusel = opcode == OP_ANDI ? ALU_ANND :
             opcode == OP_ORI ? ALU_OOR :
             opcode != OP_RTYPE ? ALU_ADD :
             funct == FN_SUB ? ALU_SUB :
             funct == FN_AND ? ALU_ANND :
             funct == FN_OR ? ALU_OOR :
             funct == FN_NOR ? ALU_NOOR :
             funct == FN_SLT ? ALU_SLT :
             funct == FN_SLL ? ALU_SLL :
             funct == FN_SRL ? ALU_SRL : ALU_ADD;
endmodule

// File: rtl/mips_multi_control.sv
// mips_multi_control: multicycle MIPS main controller, one instruction in flight, 3-5 cycles each
module mips_multi_control
  import my_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode_i,
  input  logic [5:0]           funct_i,
  input  logic                 zeroflag_i,
  output logic                 iord_o,
  output logic                 memwrite_o,
  output logic                 irwrite_o,
  output logic                 regwrite_o,
  output logic [1:0]           regdst_o,
  output logic [1:0]           memtoreg_o,
  output logic [1:0]           alusrca_o,
  output logic [2:0]           alusrcb_o,
  output logic [SEL_WIDTH-1:0] alusel_o,
  output logic [1:0]           pcsrc_o,
  output logic                 pcen_o,
  output logic                 illegal_o
);
  state_t  state, next;
  ctrl_t   ctrl;
  alusel_t dec_sel;
  alu_decoder u_dec (.opcode(opcode_i), .funct(funct_i), .alusel(dec_sel));
  function automatic state_t decode_next(logic [5:0] op, logic [5:0] fn);
    return op == OP_RTYPE ?
             (fn == FN_JR ? JR :
              fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLL, FN_SRL} ? REXE : ILL) :
           op inside {OP_LW, OP_SW} ? MEMADR :
           op inside {OP_BEQ, OP_BNE} ? BRANCH :
           op inside {OP_ADDI, OP_ANDI, OP_ORI} ? IEXE :
           op == OP_J ? JUMP :
           op == OP_JAL ? JAL : ILL;
  endfunction
  // Outputs are computed for the state being entered so they come straight off flops
  function automatic ctrl_t ctrl_of(state_t s, alusel_t sel, logic [5:0] op);
    ctrl_t c;
    c = '0;
    c.alusel = ALU_ADD;
    case (s)
      FETCH:  begin c.irwrite = 1'b1; c.srcb = SRCB_FOUR; c.pcwrite = 1'b1; end
      DECODE: c.srcb = SRCB_IMMSH;
      MEMADR: begin c.srca = SRCA_A; c.srcb = SRCB_IMM; end
      MEMRD:  c.iord = 1'b1;
      MEMWB:  begin c.regwrite = 1'b1; c.regdst = REGDST_RT; c.memtoreg = MTR_MEM; end
      MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
      REXE: begin
        c.srca   = (sel == ALU_SLL || sel == ALU_SRL) ? SRCA_B : SRCA_A;
        c.srcb   = (sel == ALU_SLL || sel == ALU_SRL) ? SRCB_SHAMT : SRCB_B;
        c.alusel = sel;
      end
      RWB:    begin c.regwrite = 1'b1; c.regdst = REGDST_RD; c.memtoreg = MTR_ALU; end
      IEXE:   begin c.srca = SRCA_A; c.srcb = op == OP_ADDI ? SRCB_IMM : SRCB_ZIMM; c.alusel = sel; end
      IWB:    begin c.regwrite = 1'b1; c.regdst = REGDST_RT; end
      BRANCH: begin
        c.srca = SRCA_A; c.srcb = SRCB_B; c.alusel = ALU_SUB; c.pcsrc = PCSRC_OUT;
        c.branch = 1'b1; c.bne = op == OP_BNE;
      end
      JUMP:   begin c.pcsrc = PCSRC_JMP; c.pcwrite = 1'b1; end
      JAL: begin
        c.pcsrc = PCSRC_JMP; c.pcwrite = 1'b1;
        c.regwrite = 1'b1; c.regdst = REGDST_R31; c.memtoreg = MTR_PC;
      end
      JR:     begin c.pcsrc = PCSRC_A; c.pcwrite = 1'b1; end
      ILL:    c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:  next = DECODE;
      DECODE: next = decode_next(opcode_i, funct_i);
      MEMADR: next = opcode_i == OP_LW ? MEMRD : MEMWR;
      MEMRD:  next = MEMWB;
      REXE:   next = RWB;
      IEXE:   next = IWB;
      default: next = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RST;
      ctrl  <= '0;
    end else begin
      state <= next;
      ctrl  <= ctrl_of(next, dec_sel, opcode_i);
    end
  assign iord_o     = ctrl.iord;
  assign memwrite_o = ctrl.memwrite;
  assign irwrite_o  = ctrl.irwrite;
  assign regwrite_o = ctrl.regwrite;
  assign regdst_o   = ctrl.regdst;
  assign memtoreg_o = ctrl.memtoreg;
  assign alusrca_o  = ctrl.srca;
  assign alusrcb_o  = ctrl.srcb;
  assign alusel_o   = ctrl.alusel;
  assign pcsrc_o    = ctrl.pcsrc;
  assign illegal_o  = ctrl.illegal;
  // Branch decision comes from the live ALU zero flag, so it bypasses the output flops
  assign pcen_o = ctrl.pcwrite | (ctrl.branch & (zeroflag_i ^ ctrl.bne));
endmodule

// File: tb/tb_mips_multi_control.sv
// tb_mips_multi_control: random instruction stream checked cycle by cycle against a per-instruction model
module tb_mips_multi_control;
  import my_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1, zf = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic iord, memwrite, irwrite, regwrite, pcen, illegal;
  logic [1:0] regdst, memtoreg, srca, pcsrc;
  logic [2:0] srcb;
  logic [SEL_WIDTH-1:0] alusel;
  int checks = 0, errors = 0;
  logic [19:0] eq[$];
  int ebr[$];
  logic [19:0] cap[8];
  wire [19:0] obs = {iord, memwrite, irwrite, regwrite, regdst, memtoreg, srca, srcb, alusel, pcsrc, pcen, illegal};

  mips_multi_control dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .funct_i(funct), .zeroflag_i(zf),
    .iord_o(iord), .memwrite_o(memwrite), .irwrite_o(irwrite), .regwrite_o(regwrite),
    .regdst_o(regdst), .memtoreg_o(memtoreg), .alusrca_o(srca), .alusrcb_o(srcb),
    .alusel_o(alusel), .pcsrc_o(pcsrc), .pcen_o(pcen), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [19:0] got, logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [19:0] mk(bit iord_e, bit mw, bit irw, bit rw, bit [1:0] rd, bit [1:0] mtr,
                                     bit [1:0] sa, bit [2:0] sb, bit [2:0] sel, bit [1:0] pcs, bit pe, bit ill);
    return {iord_e, mw, irw, rw, rd, mtr, sa, sb, sel, pcs, pe, ill};
  endfunction

  function automatic int rfn_sel(logic [5:0] fn);
    case (fn)
      6'h20: return int'(ALU_ADD);
      6'h22: return int'(ALU_SUB);
      6'h24: return int'(ALU_ANND);
      6'h25: return int'(ALU_OOR);
      6'h27: return int'(ALU_NOOR);
      6'h2A: return int'(ALU_SLT);
      6'h00: return int'(ALU_SLL);
      6'h02: return int'(ALU_SRL);
      default: return -1;
    endcase
  endfunction

  // Expected outputs for every cycle of one instruction, FETCH first
  task automatic plan(logic [5:0] op, logic [5:0] fn);
    int s;
    bit sh;
    eq = {mk(0,0,1,0,0,0,0,1,0,0,1,0), mk(0,0,0,0,0,0,0,3,0,0,0,0)};
    ebr = {0, 0};
    s = rfn_sel(fn);
    sh = fn == 6'h00 || fn == 6'h02;
    if (op == 6'h00 && fn == 6'h08) eq.push_back(mk(0,0,0,0,0,0,0,0,0,3,1,0));
    else if (op == 6'h00 && s >= 0) begin
      eq.push_back(mk(0,0,0,0,0,0, sh ? 2'd2 : 2'd1, sh ? 3'd5 : 3'd0, 3'(s), 0,0,0));
      eq.push_back(mk(0,0,0,1,1,0,0,0,0,0,0,0));
    end else if (op == 6'h23) begin
      eq.push_back(mk(0,0,0,0,0,0,1,2,0,0,0,0));
      eq.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0));
      eq.push_back(mk(0,0,0,1,0,1,0,0,0,0,0,0));
    end else if (op == 6'h2B) begin
      eq.push_back(mk(0,0,0,0,0,0,1,2,0,0,0,0));
      eq.push_back(mk(1,1,0,0,0,0,0,0,0,0,0,0));
    end else if (op == 6'h04 || op == 6'h05) begin
      eq.push_back(mk(0,0,0,0,0,0,1,0,3'(ALU_SUB),1,0,0));
      ebr.push_back(op == 6'h04 ? 1 : 2);
    end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D) begin
      eq.push_back(mk(0,0,0,0,0,0,1, op == 6'h08 ? 3'd2 : 3'd4,
                      op == 6'h08 ? 3'(ALU_ADD) : op == 6'h0C ? 3'(ALU_ANND) : 3'(ALU_OOR), 0,0,0));
      eq.push_back(mk(0,0,0,1,0,0,0,0,0,0,0,0));
    end else if (op == 6'h02) eq.push_back(mk(0,0,0,0,0,0,0,0,0,2,1,0));
    else if (op == 6'h03) eq.push_back(mk(0,0,0,1,2,2,0,0,0,2,1,0));
    else eq.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1));
    while (ebr.size() < eq.size()) ebr.push_back(0);
  endtask

  task automatic run(logic [5:0] op, logic [5:0] fn, int abort_at = -1);
    logic [19:0] e;
    plan(op, fn);
    for (int i = 0; i < eq.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin opcode = op; funct = fn; end
      zf = 1'($urandom_range(0, 1));
      #1;
      e = eq[i];
      if (ebr[i] != 0) e[1] = ebr[i] == 1 ? zf : ~zf;
      cap[i] = obs;
      chk($sformatf("op%02h_fn%02h_cyc%0d", op, fn, i), obs, e);
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1 chk("async_reset_mid_instr", obs, '0);
        @(negedge clk);
        #1 chk("reset_held", obs, '0);
        rst_n = 1'b1;
        #1 chk("rst_state_after_release", obs, '0);
        return;
      end
    end
  endtask

  logic [5:0] ops[12] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h02, 6'h03};
  logic [5:0] fns[9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h08};

  initial begin
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", obs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_state", obs, '0);
    plan(6'h23, 0); chk("model_lw_len", 20'(eq.size()), 20'd5);
    plan(6'h2B, 0); chk("model_sw_len", 20'(eq.size()), 20'd4);
    plan(6'h04, 0); chk("model_beq_len", 20'(eq.size()), 20'd3);
    plan(6'h3F, 0); chk("model_ill_len", 20'(eq.size()), 20'd3);
    run(6'h00, 6'h20);
    chk("add_fetch", cap[0], 20'h20082);
    chk("add_rexe", cap[2], 20'h00400);
    chk("add_rwb", cap[3], 20'h14000);
    run(6'h23, 0);
    chk("lw_memrd", cap[3], 20'h80000);
    chk("lw_memwb", cap[4], 20'h11000);
    run(6'h2B, 0);
    chk("sw_memwr", cap[3], 20'hC0000);
    run(6'h00, 6'h00);
    chk("sll_rexe", cap[2], 20'h00AE0);
    run(6'h0D, 0);
    chk("ori_iexe", cap[2], 20'h00630);
    chk("ori_iwb", cap[3], 20'h10000);
    run(6'h03, 0);
    chk("jal", cap[2], 20'h1A00A);
    run(6'h3F, 0);
    chk("ill_op", cap[2], 20'h00001);
    run(6'h00, 6'h3F);
    chk("ill_fn", cap[2], 20'h00001);
    for (int i = 0; i < 8; i++) begin run(6'h04, 0); run(6'h05, 0); end
    run(6'h23, 0, 3);
    run(6'h00, 6'h08);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) run(6'($urandom), 6'($urandom));
      else run(ops[$urandom_range(0, 11)], fns[$urandom_range(0, 8)]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
